bpsi_cmd_parser: RTL and testbench

Receive-side counterpart of the mfpga-to-mainPC arbiter. It consumes the byte stream that `slave_comm` recovers from the mainPC link (`rd_data_vld_o` / `rd_data_o`) and deframes, checks and validates each frame. It then replays accepted frames as the 32-bit word bursts that `pmt_master_sel` expects, or as single-word ADC-start commands for `scan_cmd_ctrl`. Malformed, truncated and stalled frames are dropped and counted.

---
 rtl/bpsi_pkg.sv | 18 +
 rtl/parser_word_buf.sv | 32 +++
 rtl/bpsi_cmd_parser.sv | 141 ++++++++++++++
 tb/tb_bpsi_cmd_parser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsi_pkg.sv
// rtl/bpsi_pkg.sv - shared constants and state type for the mainPC command parser
package bpsi_pkg;
    localparam logic [7:0] HDR_BYTE0     = 8'h55;
    localparam logic [7:0] HDR_BYTE1     = 8'hAA;
    localparam logic [7:0] CMD_PMT_WR    = 8'h01;
    localparam logic [7:0] CMD_ADC_START = 8'h02;
    localparam int         ERR_CNT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_REPLAY
    } parser_state_t;
endpackage

// File: rtl/parser_word_buf.sv
// rtl/parser_word_buf.sv - payload word buffer with self-advancing write pointer and registered read
module parser_word_buf #(
    parameter int  MAX_WORDS = 8,
    localparam int AW        = $clog2(MAX_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    output logic [AW-1:0] wr_ptr,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_ptr,
    output logic [31:0]   rd_data
);
    logic [31:0] mem [MAX_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) wr_ptr <= '0;
        else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
    end

    // Read data only moves on rd_en so the replay output holds between bursts.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_ptr];
    end
endmodule

// File: rtl/bpsi_cmd_parser.sv
// rtl/bpsi_cmd_parser.sv - deframes mainPC link bytes into PMT word bursts and ADC-start commands
module bpsi_cmd_parser
    import bpsi_pkg::*;
#(
    parameter int          MAX_WORDS      = 8,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter logic [15:0] HEADER         = {HDR_BYTE0, HDR_BYTE1}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_data_vld_i,
    input  logic [7:0]           rd_data_i,
    output logic [31:0]          pmt_master_spi_data_o,
    output logic                 pmt_master_spi_vld_o,
    output logic [31:0]          pmt_adc_start_data_o,
    output logic                 pmt_adc_start_vld_o,
    output logic                 parser_busy_o,
    output logic                 frame_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    localparam int            AW      = $clog2(MAX_WORDS);
    localparam int            GW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]    MAX_LEN = 8'(MAX_WORDS);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

    parser_state_t state, state_nxt;
    logic [7:0]    cmd, len, csum;
    logic [31:0]   asm_word, wr_word;
    logic [1:0]    byte_cnt;
    logic [GW-1:0] gap;
    logic [AW-1:0] wr_ptr, rd_idx, rd_ptr;
    logic          wr_en, rd_en, clr, abort, replay_err, gap_run, cmd_ok, len_ok, csum_ok;

    assign gap_run = state inside {S_HDR1, S_CMD, S_LEN, S_DATA, S_CSUM};
    assign cmd_ok  = rd_data_i == CMD_PMT_WR || rd_data_i == CMD_ADC_START;
    assign len_ok  = rd_data_i != 8'd0 && rd_data_i <= MAX_LEN &&
                     (cmd != CMD_ADC_START || rd_data_i == 8'd1);
    assign csum_ok = rd_data_i == csum;
    assign wr_word = {asm_word[23:0], rd_data_i};
    assign clr     = state == S_IDLE || abort;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        replay_err = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_ptr     = '0;
        case (state)
            S_IDLE: if (rd_data_vld_i && rd_data_i == HEADER[15:8]) state_nxt = S_HDR1;
            S_HDR1: if (rd_data_vld_i) begin
                if (rd_data_i == HEADER[7:0]) state_nxt = S_CMD;
                else if (rd_data_i != HEADER[15:8]) state_nxt = S_IDLE;
            end
            S_CMD: if (rd_data_vld_i) begin
                if (cmd_ok) state_nxt = S_LEN;
                else abort = 1'b1;
            end
            S_LEN: if (rd_data_vld_i) begin
                if (len_ok) state_nxt = S_DATA;
                else abort = 1'b1;
            end
            S_DATA: if (rd_data_vld_i && byte_cnt == 2'd3) begin
                wr_en = 1'b1;
                if (8'(wr_ptr) == len - 8'd1) state_nxt = S_CSUM;
            end
            S_CSUM: if (rd_data_vld_i) begin
                if (csum_ok) begin
                    state_nxt = S_REPLAY;
                    rd_en     = cmd == CMD_PMT_WR;
                end else begin
                    abort = 1'b1;
                end
            end
            S_REPLAY: begin
                // A stray byte here is counted but never cuts the burst short.
                replay_err = rd_data_vld_i;
                if (cmd == CMD_ADC_START || 8'(rd_idx) == len - 8'd1) begin
                    state_nxt = S_IDLE;
                end else begin
                    rd_en  = 1'b1;
                    rd_ptr = rd_idx + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (gap_run && !rd_data_vld_i && gap == GAP_MAX) abort = 1'b1;
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd                  <= '0;
            len                  <= '0;
            csum                 <= '0;
            asm_word             <= '0;
            byte_cnt             <= '0;
            gap                  <= '0;
            rd_idx               <= '0;
            pmt_adc_start_data_o <= '0;
            frame_err_o          <= 1'b0;
            err_cnt_o            <= '0;
        end else begin
            frame_err_o <= abort || replay_err;
            if ((abort || replay_err) && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
            gap    <= (gap_run && !rd_data_vld_i) ? gap + 1'b1 : '0;
            rd_idx <= (state == S_REPLAY) ? rd_idx + 1'b1 : '0;
            if (clr) csum <= '0;
            else if (rd_data_vld_i && state inside {S_CMD, S_LEN, S_DATA}) csum <= csum ^ rd_data_i;
            if (clr) byte_cnt <= '0;
            else if (rd_data_vld_i && state == S_DATA) byte_cnt <= byte_cnt + 1'b1;
            if (rd_data_vld_i && state == S_DATA) asm_word <= wr_word;
            if (rd_data_vld_i && state == S_CMD && cmd_ok) cmd <= rd_data_i;
            if (rd_data_vld_i && state == S_LEN) len <= rd_data_i;
            // An ADC frame carries exactly one word, still sitting in the assembly register.
            if (rd_data_vld_i && state == S_CSUM && csum_ok && cmd == CMD_ADC_START)
                pmt_adc_start_data_o <= asm_word;
        end
    end

    assign parser_busy_o        = state != S_IDLE;
    assign pmt_master_spi_vld_o = state == S_REPLAY && cmd == CMD_PMT_WR;
    assign pmt_adc_start_vld_o  = state == S_REPLAY && cmd == CMD_ADC_START;

    parser_word_buf #(.MAX_WORDS(MAX_WORDS)) u_buf (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .wr_ptr  (wr_ptr),
        .rd_en   (rd_en),
        .rd_ptr  (rd_ptr),
        .rd_data (pmt_master_spi_data_o)
    );
endmodule

// File: tb/tb_bpsi_cmd_parser.sv
// tb/tb_bpsi_cmd_parser.sv - directed and randomized frame checks for bpsi_cmd_parser
module tb_bpsi_cmd_parser;
    localparam int MAX_WORDS      = 8;
    localparam int TIMEOUT_CYCLES = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [7:0]  din = '0;
    logic [31:0] spi_data, adc_data;
    logic        spi_vld, adc_vld, busy, ferr;
    logic [15:0] ecnt;

    bpsi_cmd_parser #(
        .MAX_WORDS      (MAX_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HEADER         (16'h55AA)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .rd_data_vld_i         (vld),
        .rd_data_i             (din),
        .pmt_master_spi_data_o (spi_data),
        .pmt_master_spi_vld_o  (spi_vld),
        .pmt_adc_start_data_o  (adc_data),
        .pmt_adc_start_vld_o   (adc_vld),
        .parser_busy_o         (busy),
        .frame_err_o           (ferr),
        .err_cnt_o             (ecnt)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total = 0;
    int          spi_seen = 0;
    int          adc_seen = 0;
    int          both_seen = 0;
    int          exp_err = 0;
    logic [31:0] last_spi = '0;
    logic [31:0] last_adc = '0;
    logic [31:0] fw [16];

    always @(negedge clk) begin
        if (spi_vld) spi_seen++;
        if (adc_vld) adc_seen++;
        if (spi_vld && adc_vld) both_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        vld = 1'b1;
        din = b;
        tick(1);
        vld = 1'b0;
        din = '0;
    endtask

    task automatic put(input logic [7:0] b, input int gmax);
        tick(int'($urandom_range(0, gmax)));
        send_byte(b);
    endtask

    function automatic bit cmd_bad(input logic [7:0] cmd);
        return cmd != 8'h01 && cmd != 8'h02;
    endfunction

    function automatic bit len_bad(input logic [7:0] cmd, input logic [7:0] len);
        return len == 8'h00 || int'(len) > MAX_WORDS || (cmd == 8'h02 && len != 8'h01);
    endfunction

    function automatic bit frame_bad(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] flip);
        return cmd_bad(cmd) || len_bad(cmd, len) || flip != 8'h00;
    endfunction

    // Byte stream stops right after the first byte that makes the frame illegal.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] flip, input int gmax);
        logic [7:0] x;
        logic [7:0] b;
        put(8'h55, gmax);
        put(8'hAA, gmax);
        put(cmd, gmax);
        if (cmd_bad(cmd)) return;
        put(len, gmax);
        if (len_bad(cmd, len)) return;
        x = cmd ^ len;
        for (int w = 0; w < int'(len); w++) begin
            for (int k = 3; k >= 0; k--) begin
                b = fw[w][8*k +: 8];
                x = x ^ b;
                put(b, gmax);
            end
        end
        put(x ^ flip, gmax);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] flip, input int gmax);
        int s0;
        int a0;
        s0 = spi_seen;
        a0 = adc_seen;
        send_frame(cmd, len, flip, gmax);
        if (frame_bad(cmd, len, flip)) begin
            if (exp_err < 32'hFFFF) exp_err++;
            check({tag, " err pulse"}, 32'(ferr), 1);
            check({tag, " err count"}, 32'(ecnt), exp_err);
            tick(1);
            check({tag, " err pulse width"}, 32'(ferr), 0);
            tick(9);
            check({tag, " no strobes"}, spi_seen - s0 + adc_seen - a0, 0);
            check({tag, " idle"}, 32'(busy), 0);
        end else if (cmd == 8'h01) begin
            for (int k = 0; k < int'(len); k++) begin
                check({tag, " spi vld"}, 32'(spi_vld), 1);
                check({tag, " spi data"}, spi_data, fw[k]);
                tick(1);
            end
            last_spi = fw[int'(len) - 1];
            check({tag, " burst end"}, 32'(spi_vld), 0);
            check({tag, " busy end"}, 32'(busy), 0);
            check({tag, " adc quiet"}, adc_seen - a0, 0);
            check({tag, " adc hold"}, adc_data, last_adc);
            check({tag, " err count"}, 32'(ecnt), exp_err);
        end else begin
            check({tag, " adc vld"}, 32'(adc_vld), 1);
            check({tag, " adc data"}, adc_data, fw[0]);
            check({tag, " spi low"}, 32'(spi_vld), 0);
            last_adc = fw[0];
            tick(1);
            check({tag, " adc pulse width"}, 32'(adc_vld), 0);
            check({tag, " busy end"}, 32'(busy), 0);
            check({tag, " spi quiet"}, spi_seen - s0, 0);
            check({tag, " spi hold"}, spi_data, last_spi);
            check({tag, " err count"}, 32'(ecnt), exp_err);
        end
    endtask

    initial begin
        int n;
        int s0;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset spi data", spi_data, 0);
        check("reset spi vld", 32'(spi_vld), 0);
        check("reset adc data", adc_data, 0);
        check("reset adc vld", 32'(adc_vld), 0);
        check("reset busy", 32'(busy), 0);
        check("reset err pulse", 32'(ferr), 0);
        check("reset err count", 32'(ecnt), 0);
        tick(2);

        fw[0] = 32'h0000_0400;
        run_frame("pmt one", 8'h01, 8'h01, 8'h00, 3);
        fw[0] = 32'h0000_76C8;
        fw[1] = 32'h0000_0480;
        run_frame("pmt two", 8'h01, 8'h02, 8'h00, 0);
        fw[0] = 32'h0000_0403;
        run_frame("adc", 8'h02, 8'h01, 8'h00, 2);

        fw[0] = 32'h0000_0400;
        run_frame("bad csum", 8'h01, 8'h01, 8'h01, 2);
        run_frame("len9", 8'h01, 8'h09, 8'h00, 2);
        run_frame("cmd7", 8'h07, 8'h01, 8'h00, 2);
        for (int k = 0; k < 16; k++) fw[k] = $urandom;
        run_frame("after errors", 8'h01, 8'h03, 8'h00, 2);

        run_frame("len max", 8'h01, 8'(MAX_WORDS), 8'h00, 1);
        run_frame("len0", 8'h01, 8'h00, 8'h00, 1);
        run_frame("adc len2", 8'h02, 8'h02, 8'h00, 1);

        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h02);
        n = 0;
        while (ferr !== 1'b1 && n < TIMEOUT_CYCLES + 100) begin
            tick(1);
            n++;
        end
        exp_err++;
        check("timeout pulse", 32'(ferr), 1);
        check("timeout gap", 32'(n >= TIMEOUT_CYCLES - 2 && n <= TIMEOUT_CYCLES + 2), 1);
        check("timeout count", 32'(ecnt), exp_err);
        check("timeout idle", 32'(busy), 0);
        tick(3);
        for (int k = 0; k < 16; k++) fw[k] = $urandom;
        run_frame("after timeout", 8'h01, 8'h02, 8'h00, 2);

        send_byte(8'h13);
        tick(2);
        send_byte(8'h55);
        run_frame("lead 55", 8'h02, 8'h01, 8'h00, 2);
        send_byte(8'h55);
        tick(2);
        send_byte(8'h12);
        run_frame("hdr abort", 8'h01, 8'h01, 8'h00, 2);

        for (int k = 0; k < 16; k++) fw[k] = $urandom;
        send_frame(8'h01, 8'h04, 8'h00, 2);
        check("rst word0", spi_data, fw[0]);
        tick(1);
        check("rst word1", spi_data, fw[1]);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst spi vld", 32'(spi_vld), 0);
        check("rst spi data", spi_data, 0);
        check("rst adc data", adc_data, 0);
        check("rst adc vld", 32'(adc_vld), 0);
        check("rst busy", 32'(busy), 0);
        check("rst err count", 32'(ecnt), 0);
        s0 = spi_seen;
        tick(8);
        check("rst no burst tail", spi_seen - s0, 0);
        exp_err  = 0;
        last_spi = '0;
        last_adc = '0;
        run_frame("after reset", 8'h01, 8'h02, 8'h00, 2);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [7:0] c;
            logic [7:0] l;
            logic [7:0] f;
            r = int'($urandom_range(0, 9));
            if (r < 5) c = 8'h01;
            else if (r < 8) c = 8'h02;
            else begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h01 || c == 8'h02) c = 8'h07;
            end
            r = int'($urandom_range(0, 9));
            if (c == 8'h02) l = (r < 8) ? 8'h01 : 8'($urandom_range(0, 3));
            else l = (r < 8) ? 8'($urandom_range(1, MAX_WORDS)) : 8'($urandom_range(0, 12));
            f = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int k = 0; k < 16; k++) fw[k] = $urandom;
            run_frame("random", c, l, f, int'($urandom_range(0, 6)));
            tick(int'($urandom_range(1, 5)));
        end

        check("strobes exclusive", both_seen, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
